nav_sequencer: RTL and testbench

NAV_SEQUENCER -- requirements
Module: nav_sequencer

---
 rtl/nav_pkg.sv | 38 +++
 rtl/nav_timer.sv | 42 ++++
 rtl/nav_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_nav_sequencer.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_pkg.sv
// nav_pkg: shared definitions for the rover navigation sequencer.
//   - nav_state_e : sequencer state encoding; the numeric value is exported
//                   on the sequencer's debug `state` port.
//   - loc_r       : extracts the range field from a {theta, r} location word.
//   - loc_theta   : extracts the angle field from a {theta, r} location word.
// The field helpers work on a 32-bit zero-extended word so they can serve any
// R_W/TH_W combination without needing package parameters.
package nav_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SENSE1     = 4'd1,
        ST_SETTLE1    = 4'd2,
        ST_PROBE_TX   = 4'd3,
        ST_PROBE_WAIT = 4'd4,
        ST_SENSE2     = 4'd5,
        ST_SETTLE2    = 4'd6,
        ST_ORIENT     = 4'd7,
        ST_HEAD_CALC  = 4'd8,
        ST_PATH_CALC  = 4'd9,
        ST_CMD_TX     = 4'd10,
        ST_MOVE_WAIT  = 4'd11,
        ST_SENSE3     = 4'd12,
        ST_CHECK      = 4'd13,
        ST_DONE       = 4'd14,
        ST_FAIL       = 4'd15
    } nav_state_e;

    function automatic logic [31:0] loc_r(input logic [31:0] loc, input int unsigned r_w);
        return loc & ((32'd1 << r_w) - 32'd1);
    endfunction

    function automatic logic [31:0] loc_theta(input logic [31:0] loc, input int unsigned r_w,
                                              input int unsigned th_w);
        return (loc >> r_w) & ((32'd1 << th_w) - 32'd1);
    endfunction

endpackage

// File: rtl/nav_timer.sv
// nav_timer: loadable down-counter with zero flag.
// Ports:
//   clock    - clock
//   reset    - asynchronous active-low reset (count forced to 0)
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - value to load
//   zero     - count is zero
// The counter decrements every cycle it is not loaded and stops at zero, so a
// state that loads N-1 on entry and leaves when `zero` is seen lasts N cycles.
module nav_timer #(
    parameter int TIMER_W = 40
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/nav_sequencer.sv
// nav_sequencer: rover navigation sequencer.
// Senses the rover position, sends an orientation probe move, senses again,
// asks the orientation helper for the current heading and the heading to the
// target, asks the path helper for a move command, transmits it over IR, waits
// for the move to complete and checks arrival; retries up to MAX_ATTEMPTS.
// Ports:
//   clock, reset                  - clock, asynchronous active-low reset
//   enable, abort                 - start pulse, return-to-IDLE request
//   target_location/rover_location- target and sensed {theta, r} positions
//   run_ultrasound/ultrasound_done- sense handshake
//   orient_start/from/to/done/result - orientation helper handshake
//   path_start/path_done/path_cmd - path helper handshake
//   cmp_start/cmp_done/cmp_equal  - arrival compare handshake
//   move_command, transmit_ir     - IR payload and transmit enable
//   orientation                   - last heading reported by the orientation helper
//   attempt                       - move iterations used
//   busy, reached_target, failed  - status
//   state                         - debug state code
module nav_sequencer
    import nav_pkg::*;
#(
    parameter int R_W          = 8,
    parameter int TH_W         = 4,
    parameter int SETTLE_CYC   = 27000000,
    parameter int UNIT_CYC     = 27000000,
    parameter int SEND_CYC     = 27000000,
    parameter int PROBE_CMD    = 'h00A,
    parameter int TIMEOUT_CYC  = 54000000,
    parameter int MAX_ATTEMPTS = 4,
    parameter int TIMER_W      = 40
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  abort,
    input  logic [R_W+TH_W-1:0]   target_location,
    input  logic [R_W+TH_W-1:0]   rover_location,
    output logic                  run_ultrasound,
    input  logic                  ultrasound_done,
    output logic                  orient_start,
    output logic [R_W+TH_W-1:0]   orient_from,
    output logic [R_W+TH_W-1:0]   orient_to,
    input  logic                  orient_done,
    input  logic [4:0]            orient_result,
    output logic                  path_start,
    input  logic                  path_done,
    input  logic [R_W+TH_W-1:0]   path_cmd,
    output logic                  cmp_start,
    input  logic                  cmp_done,
    input  logic                  cmp_equal,
    output logic [R_W+TH_W-1:0]   move_command,
    output logic                  transmit_ir,
    output logic [4:0]            orientation,
    output logic [2:0]            attempt,
    output logic                  busy,
    output logic                  reached_target,
    output logic                  failed,
    output logic [3:0]            state
);

    localparam int LOC_W = R_W + TH_W;

    localparam logic [TIMER_W-1:0] SETTLE_T  = TIMER_W'(SETTLE_CYC);
    localparam logic [TIMER_W-1:0] SEND_T    = TIMER_W'(SEND_CYC);
    localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(TIMEOUT_CYC);
    localparam logic [LOC_W-1:0]   PROBE_LOC = LOC_W'(PROBE_CMD);
    localparam int                 PROBE_R   = int'(loc_r(32'(PROBE_CMD), R_W));
    localparam logic [TIMER_W-1:0] PROBE_LEN = TIMER_W'(UNIT_CYC) * TIMER_W'(PROBE_R);

    // Timer value to load on entry so that the state lasts n cycles.
    function automatic logic [TIMER_W-1:0] ticks(input logic [TIMER_W-1:0] n);
        return (n == '0) ? '0 : n - TIMER_W'(1);
    endfunction

    nav_state_e         state_q, state_d;
    logic [2:0]         attempt_q, attempt_d;
    logic               reached_q, reached_d;
    logic               failed_q, failed_d;
    logic               run_us_q, run_us_d;
    logic               orient_start_q, orient_start_d;
    logic               path_start_q, path_start_d;
    logic               cmp_start_q, cmp_start_d;
    logic               transmit_ir_q, transmit_ir_d;
    logic [LOC_W-1:0]   move_command_q, move_command_d;
    logic [LOC_W-1:0]   orient_from_q, orient_from_d;
    logic [LOC_W-1:0]   orient_to_q, orient_to_d;
    logic [4:0]         orientation_q, orientation_d;
    logic [LOC_W-1:0]   orig_q, orig_d;
    logic [LOC_W-1:0]   upd_q, upd_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_zero;

    // Move duration: both command fields widened to TIMER_W before the
    // multiply so large UNIT_CYC values cannot overflow.
    logic [31:0]        cmd_r;
    logic [31:0]        cmd_th;
    logic [TIMER_W-1:0] move_len;

    assign cmd_r    = loc_r(32'(move_command_q), R_W);
    assign cmd_th   = loc_theta(32'(move_command_q), R_W, TH_W);
    assign move_len = TIMER_W'(UNIT_CYC) * (TIMER_W'(cmd_r) + TIMER_W'(cmd_th));

    nav_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        attempt_d      = attempt_q;
        reached_d      = reached_q;
        failed_d       = failed_q;
        run_us_d       = 1'b0;
        orient_start_d = 1'b0;
        path_start_d   = 1'b0;
        cmp_start_d    = 1'b0;
        transmit_ir_d  = transmit_ir_q;
        move_command_d = move_command_q;
        orient_from_d  = orient_from_q;
        orient_to_d    = orient_to_q;
        orientation_d  = orientation_q;
        orig_d         = orig_q;
        upd_d          = upd_q;
        tmr_load       = 1'b0;
        tmr_val        = '0;

        if (abort) begin
            state_d       = ST_IDLE;
            transmit_ir_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (enable) begin
                        attempt_d = '0;
                        reached_d = 1'b0;
                        failed_d  = 1'b0;
                        run_us_d  = 1'b1;
                        state_d   = ST_SENSE1;
                        tmr_load  = 1'b1;
                        tmr_val   = ticks(TIMEOUT_T);
                    end
                end

                ST_SENSE1, ST_SENSE2, ST_SENSE3: begin
                    if (ultrasound_done) begin
                        tmr_load = 1'b1;
                        if (state_q == ST_SENSE3) begin
                            cmp_start_d = 1'b1;
                            state_d     = ST_CHECK;
                            tmr_val     = ticks(TIMEOUT_T);
                        end else begin
                            state_d = (state_q == ST_SENSE1) ? ST_SETTLE1 : ST_SETTLE2;
                            tmr_val = ticks(SETTLE_T);
                        end
                    end else if (tmr_zero) begin
                        state_d  = ST_FAIL;
                        failed_d = 1'b1;
                    end
                end

                ST_SETTLE1: begin
                    if (tmr_zero) begin
                        orig_d         = rover_location;
                        move_command_d = PROBE_LOC;
                        transmit_ir_d  = 1'b1;
                        state_d        = ST_PROBE_TX;
                        tmr_load       = 1'b1;
                        tmr_val        = ticks(SEND_T);
                    end
                end

                ST_PROBE_TX: begin
                    if (tmr_zero) begin
                        transmit_ir_d = 1'b0;
                        tmr_load      = 1'b1;
                        // A zero-length probe skips the wait entirely.
                        if (PROBE_LEN == '0) begin
                            run_us_d = 1'b1;
                            state_d  = ST_SENSE2;
                            tmr_val  = ticks(TIMEOUT_T);
                        end else begin
                            state_d = ST_PROBE_WAIT;
                            tmr_val = ticks(PROBE_LEN);
                        end
                    end
                end

                ST_PROBE_WAIT: begin
                    if (tmr_zero) begin
                        run_us_d = 1'b1;
                        state_d  = ST_SENSE2;
                        tmr_load = 1'b1;
                        tmr_val  = ticks(TIMEOUT_T);
                    end
                end

                ST_SETTLE2: begin
                    if (tmr_zero) begin
                        upd_d          = rover_location;
                        orient_from_d  = orig_q;
                        orient_to_d    = rover_location;
                        orient_start_d = 1'b1;
                        state_d        = ST_ORIENT;
                        tmr_load       = 1'b1;
                        tmr_val        = ticks(TIMEOUT_T);
                    end
                end

                ST_ORIENT: begin
                    if (orient_done) begin
                        orientation_d  = orient_result;
                        orient_from_d  = upd_q;
                        orient_to_d    = target_location;
                        orient_start_d = 1'b1;
                        state_d        = ST_HEAD_CALC;
                        tmr_load       = 1'b1;
                        tmr_val        = ticks(TIMEOUT_T);
                    end else if (tmr_zero) begin
                        state_d  = ST_FAIL;
                        failed_d = 1'b1;
                    end
                end

                ST_HEAD_CALC: begin
                    // The heading to the target is only consumed by the path
                    // helper; the orientation port keeps the rover's own heading.
                    if (orient_done) begin
                        path_start_d = 1'b1;
                        state_d      = ST_PATH_CALC;
                        tmr_load     = 1'b1;
                        tmr_val      = ticks(TIMEOUT_T);
                    end else if (tmr_zero) begin
                        state_d  = ST_FAIL;
                        failed_d = 1'b1;
                    end
                end

                ST_PATH_CALC: begin
                    if (path_done) begin
                        move_command_d = path_cmd;
                        transmit_ir_d  = 1'b1;
                        attempt_d      = attempt_q + 3'd1;
                        state_d        = ST_CMD_TX;
                        tmr_load       = 1'b1;
                        tmr_val        = ticks(SEND_T);
                    end else if (tmr_zero) begin
                        state_d  = ST_FAIL;
                        failed_d = 1'b1;
                    end
                end

                ST_CMD_TX: begin
                    if (tmr_zero) begin
                        transmit_ir_d = 1'b0;
                        tmr_load      = 1'b1;
                        // A zero-length command goes straight to sensing.
                        if (move_len == '0) begin
                            run_us_d = 1'b1;
                            state_d  = ST_SENSE3;
                            tmr_val  = ticks(TIMEOUT_T);
                        end else begin
                            state_d = ST_MOVE_WAIT;
                            tmr_val = ticks(move_len);
                        end
                    end
                end

                ST_MOVE_WAIT: begin
                    if (tmr_zero) begin
                        run_us_d = 1'b1;
                        state_d  = ST_SENSE3;
                        tmr_load = 1'b1;
                        tmr_val  = ticks(TIMEOUT_T);
                    end
                end

                ST_CHECK: begin
                    if (cmp_done) begin
                        if (cmp_equal) begin
                            reached_d = 1'b1;
                            state_d   = ST_DONE;
                        end else if (attempt_q == 3'(MAX_ATTEMPTS)) begin
                            failed_d = 1'b1;
                            state_d  = ST_FAIL;
                        end else begin
                            // Retry from the current position: it becomes both
                            // the new origin and the operand for the heading query.
                            orig_d         = rover_location;
                            upd_d          = rover_location;
                            orient_from_d  = rover_location;
                            orient_to_d    = target_location;
                            orient_start_d = 1'b1;
                            state_d        = ST_HEAD_CALC;
                            tmr_load       = 1'b1;
                            tmr_val        = ticks(TIMEOUT_T);
                        end
                    end else if (tmr_zero) begin
                        state_d  = ST_FAIL;
                        failed_d = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            attempt_q      <= '0;
            reached_q      <= 1'b0;
            failed_q       <= 1'b0;
            run_us_q       <= 1'b0;
            orient_start_q <= 1'b0;
            path_start_q   <= 1'b0;
            cmp_start_q    <= 1'b0;
            transmit_ir_q  <= 1'b0;
            move_command_q <= '0;
            orient_from_q  <= '0;
            orient_to_q    <= '0;
            orientation_q  <= '0;
            orig_q         <= '0;
            upd_q          <= '0;
        end else begin
            state_q        <= state_d;
            attempt_q      <= attempt_d;
            reached_q      <= reached_d;
            failed_q       <= failed_d;
            run_us_q       <= run_us_d;
            orient_start_q <= orient_start_d;
            path_start_q   <= path_start_d;
            cmp_start_q    <= cmp_start_d;
            transmit_ir_q  <= transmit_ir_d;
            move_command_q <= move_command_d;
            orient_from_q  <= orient_from_d;
            orient_to_q    <= orient_to_d;
            orientation_q  <= orientation_d;
            orig_q         <= orig_d;
            upd_q          <= upd_d;
        end
    end

    assign run_ultrasound = run_us_q;
    assign orient_start   = orient_start_q;
    assign orient_from    = orient_from_q;
    assign orient_to      = orient_to_q;
    assign path_start     = path_start_q;
    assign cmp_start      = cmp_start_q;
    assign move_command   = move_command_q;
    assign transmit_ir    = transmit_ir_q;
    assign orientation    = orientation_q;
    assign attempt        = attempt_q;
    assign reached_target = reached_q;
    assign failed         = failed_q;
    assign state          = state_q;
    assign busy           = !(state_q inside {ST_IDLE, ST_DONE, ST_FAIL});

endmodule

// File: tb/tb_nav_sequencer.sv
module tb_nav_sequencer;

    localparam int R_W          = 8;
    localparam int TH_W         = 4;
    localparam int LOC_W        = 12;
    localparam int SETTLE_CYC   = 4;
    localparam int UNIT_CYC     = 2;
    localparam int SEND_CYC     = 3;
    localparam int PROBE_CMD    = 'h00A;
    localparam int TIMEOUT_CYC  = 50;
    localparam int MAX_ATTEMPTS = 2;

    // Debug state codes: position in the documented state list.
    localparam logic [3:0] C_IDLE       = 4'd0;
    localparam logic [3:0] C_SENSE1     = 4'd1;
    localparam logic [3:0] C_PROBE_WAIT = 4'd4;
    localparam logic [3:0] C_SENSE2     = 4'd5;
    localparam logic [3:0] C_CMD_TX     = 4'd10;
    localparam logic [3:0] C_DONE       = 4'd14;
    localparam logic [3:0] C_FAIL       = 4'd15;

    // Handshake selectors.
    localparam int W_US   = 0;
    localparam int W_OR   = 1;
    localparam int W_PATH = 2;
    localparam int W_CMP  = 3;
    localparam int W_TX   = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             abort = 1'b0;
    logic [LOC_W-1:0] target_location = '0;
    logic [LOC_W-1:0] rover_location = '0;
    logic             ultrasound_done = 1'b0;
    logic             orient_done = 1'b0;
    logic [4:0]       orient_result = '0;
    logic             path_done = 1'b0;
    logic [LOC_W-1:0] path_cmd = '0;
    logic             cmp_done = 1'b0;
    logic             cmp_equal = 1'b0;

    logic             run_ultrasound;
    logic             orient_start;
    logic [LOC_W-1:0] orient_from;
    logic [LOC_W-1:0] orient_to;
    logic             path_start;
    logic             cmp_start;
    logic [LOC_W-1:0] move_command;
    logic             transmit_ir;
    logic [4:0]       orientation;
    logic [2:0]       attempt;
    logic             busy;
    logic             reached_target;
    logic             failed;
    logic [3:0]       state;

    int total = 0;
    int bad   = 0;

    nav_sequencer #(
        .R_W          (R_W),
        .TH_W         (TH_W),
        .SETTLE_CYC   (SETTLE_CYC),
        .UNIT_CYC     (UNIT_CYC),
        .SEND_CYC     (SEND_CYC),
        .PROBE_CMD    (PROBE_CMD),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .MAX_ATTEMPTS (MAX_ATTEMPTS),
        .TIMER_W      (40)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .abort           (abort),
        .target_location (target_location),
        .rover_location  (rover_location),
        .run_ultrasound  (run_ultrasound),
        .ultrasound_done (ultrasound_done),
        .orient_start    (orient_start),
        .orient_from     (orient_from),
        .orient_to       (orient_to),
        .orient_done     (orient_done),
        .orient_result   (orient_result),
        .path_start      (path_start),
        .path_done       (path_done),
        .path_cmd        (path_cmd),
        .cmp_start       (cmp_start),
        .cmp_done        (cmp_done),
        .cmp_equal       (cmp_equal),
        .move_command    (move_command),
        .transmit_ir     (transmit_ir),
        .orientation     (orientation),
        .attempt         (attempt),
        .busy            (busy),
        .reached_target  (reached_target),
        .failed          (failed),
        .state           (state)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic pulse_of(input int w);
        case (w)
            W_US:    return run_ultrasound;
            W_OR:    return orient_start;
            W_PATH:  return path_start;
            W_CMP:   return cmp_start;
            W_TX:    return transmit_ir;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_done(input int w, input logic v);
        case (w)
            W_US:    ultrasound_done = v;
            W_OR:    orient_done = v;
            W_PATH:  path_done = v;
            default: cmp_done = v;
        endcase
    endtask

    // Wait (bounded) until the selected output is high; n = cycles waited.
    task automatic wait_sig(input int w, input int budget, output int n);
        n = 0;
        while (pulse_of(w) !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    // Helper reply after a random latency; the start pulse must already be gone
    // one cycle after it was seen.
    task automatic respond(input int w);
        int lat;
        lat = $urandom_range(4, 1);
        for (int i = 0; i < lat; i++) begin
            step();
            if (i == 0) begin
                total++;
                if (pulse_of(w) !== 1'b0) begin
                    bad++;
                    $display("FAIL pulse_width sel=%0d got=%0b want=0", w, pulse_of(w));
                end
            end
        end
        set_done(w, 1'b1);
        step();
        set_done(w, 1'b0);
    endtask

    // One navigation run. mode: 0 full run, 1 abort in CMD_TX, 2 withhold the
    // second sense, 3 reset during PROBE_WAIT, 4 reset during PROBE_TX.
    task automatic mission(input int mode, input logic [LOC_W-1:0] cmd0,
                           input logic [LOC_W-1:0] cmd1, input bit eq0, input bit eq1);
        logic [LOC_W-1:0] tgt, loc1, loc2, loc3, cmd;
        logic [4:0]       o1;
        int               n, hi, exp_len;
        bit               eq;

        tgt = LOC_W'($urandom);
        target_location = tgt;
        enable = 1'b1;
        step();
        enable = 1'b0;
        total++;
        if (run_ultrasound !== 1'b1 || state !== C_SENSE1 || attempt !== 3'd0
            || reached_target !== 1'b0 || failed !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start run=%0b state=%0d att=%0d rch=%0b fl=%0b busy=%0b want 1/%0d/0/0/0/1",
                     run_ultrasound, state, attempt, reached_target, failed, busy, C_SENSE1);
        end

        loc1 = LOC_W'($urandom);
        rover_location = loc1;
        respond(W_US);
        wait_sig(W_TX, 50, n);
        total++;
        if (n !== SETTLE_CYC || transmit_ir !== 1'b1 || move_command !== LOC_W'(PROBE_CMD)) begin
            bad++;
            $display("FAIL settle1 cycles=%0d tx=%0b cmd=%0h want %0d/1/%0h",
                     n, transmit_ir, move_command, SETTLE_CYC, PROBE_CMD);
        end

        if (mode == 4) begin
            step();
            #3 reset = 1'b0;
            #1;
            total++;
            if (transmit_ir !== 1'b0 || state !== C_IDLE) begin
                bad++;
                $display("FAIL reset_tx tx=%0b state=%0d want 0/0", transmit_ir, state);
            end
            @(posedge clock);
            #1 reset = 1'b1;
            return;
        end

        hi = 0;
        while (transmit_ir === 1'b1 && hi < 100) begin
            hi++;
            step();
        end
        total++;
        if (hi !== SEND_CYC) begin
            bad++;
            $display("FAIL probe_tx_len got=%0d want=%0d", hi, SEND_CYC);
        end

        if (mode == 3) begin
            repeat (3) step();
            total++;
            if (state !== C_PROBE_WAIT) begin
                bad++;
                $display("FAIL probe_wait_state got=%0d want=%0d", state, C_PROBE_WAIT);
            end
            #3 reset = 1'b0;
            #1;
            total++;
            if ({run_ultrasound, orient_start, orient_from, orient_to, path_start, cmp_start,
                 move_command, transmit_ir, orientation, attempt, busy, reached_target,
                 failed, state} !== '0) begin
                bad++;
                $display("FAIL async_reset_outputs state=%0d cmd=%0h from=%0h to=%0h busy=%0b want all 0",
                         state, move_command, orient_from, orient_to, busy);
            end
            @(posedge clock);
            #1 reset = 1'b1;
            return;
        end

        wait_sig(W_US, 200, n);
        exp_len = UNIT_CYC * (PROBE_CMD % 256);
        total++;
        if (n !== exp_len || run_ultrasound !== 1'b1) begin
            bad++;
            $display("FAIL probe_wait_len got=%0d run=%0b want=%0d run=1", n, run_ultrasound, exp_len);
        end

        if (mode == 2) begin
            n = 0;
            while (state === C_SENSE2 && n < 200) begin
                n++;
                step();
            end
            total++;
            if (n !== TIMEOUT_CYC || state !== C_FAIL || failed !== 1'b1 || transmit_ir !== 1'b0) begin
                bad++;
                $display("FAIL timeout cycles=%0d state=%0d failed=%0b tx=%0b want %0d/%0d/1/0",
                         n, state, failed, transmit_ir, TIMEOUT_CYC, C_FAIL);
            end
            return;
        end

        loc2 = LOC_W'($urandom);
        rover_location = loc2;
        respond(W_US);
        wait_sig(W_OR, 50, n);
        total++;
        if (n !== SETTLE_CYC || orient_from !== loc1 || orient_to !== loc2) begin
            bad++;
            $display("FAIL orient1 cycles=%0d from=%0h to=%0h want %0d/%0h/%0h",
                     n, orient_from, orient_to, SETTLE_CYC, loc1, loc2);
        end

        o1 = 5'($urandom);
        orient_result = o1;
        respond(W_OR);
        wait_sig(W_OR, 10, n);
        total++;
        if (n !== 0 || orient_from !== loc2 || orient_to !== tgt || orientation !== o1) begin
            bad++;
            $display("FAIL orient2 wait=%0d from=%0h to=%0h ori=%0h want 0/%0h/%0h/%0h",
                     n, orient_from, orient_to, orientation, loc2, tgt, o1);
        end

        for (int it = 0; it < MAX_ATTEMPTS; it++) begin
            cmd = (it == 0) ? cmd0 : cmd1;
            eq  = (it == 0) ? eq0 : eq1;
            orient_result = 5'($urandom);
            respond(W_OR);
            wait_sig(W_PATH, 10, n);
            total++;
            if (n !== 0) begin
                bad++;
                $display("FAIL path_start wait=%0d want=0", n);
            end
            path_cmd = cmd;
            respond(W_PATH);
            wait_sig(W_TX, 10, n);
            total++;
            if (n !== 0 || move_command !== cmd || attempt !== 3'(it + 1)) begin
                bad++;
                $display("FAIL cmd_tx wait=%0d cmd=%0h att=%0d want 0/%0h/%0d",
                         n, move_command, attempt, cmd, it + 1);
            end
            if (mode == 1) begin
                total++;
                if (state !== C_CMD_TX) begin
                    bad++;
                    $display("FAIL abort_pre_state got=%0d want=%0d", state, C_CMD_TX);
                end
                abort = 1'b1;
                enable = 1'b1;
                ultrasound_done = 1'b1;
                step();
                abort = 1'b0;
                enable = 1'b0;
                ultrasound_done = 1'b0;
                total++;
                if (state !== C_IDLE || transmit_ir !== 1'b0 || run_ultrasound !== 1'b0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL abort state=%0d tx=%0b run=%0b busy=%0b want 0/0/0/0",
                             state, transmit_ir, run_ultrasound, busy);
                end
                return;
            end
            hi = 0;
            while (transmit_ir === 1'b1 && hi < 100) begin
                hi++;
                step();
            end
            total++;
            if (hi !== SEND_CYC) begin
                bad++;
                $display("FAIL cmd_tx_len got=%0d want=%0d", hi, SEND_CYC);
            end
            exp_len = UNIT_CYC * (int'(cmd[R_W-1:0]) + int'(cmd[LOC_W-1:R_W]));
            wait_sig(W_US, 700, n);
            total++;
            if (n !== exp_len || run_ultrasound !== 1'b1) begin
                bad++;
                $display("FAIL move_wait_len cmd=%0h got=%0d want=%0d", cmd, n, exp_len);
            end
            loc3 = LOC_W'($urandom);
            rover_location = loc3;
            respond(W_US);
            wait_sig(W_CMP, 10, n);
            total++;
            if (n !== 0) begin
                bad++;
                $display("FAIL cmp_start wait=%0d want=0", n);
            end
            cmp_equal = eq;
            respond(W_CMP);
            cmp_equal = 1'b0;
            if (eq) begin
                total++;
                if (state !== C_DONE || reached_target !== 1'b1 || failed !== 1'b0
                    || busy !== 1'b0 || attempt !== 3'(it + 1) || transmit_ir !== 1'b0) begin
                    bad++;
                    $display("FAIL done state=%0d rch=%0b fl=%0b busy=%0b att=%0d want %0d/1/0/0/%0d",
                             state, reached_target, failed, busy, attempt, C_DONE, it + 1);
                end
                return;
            end else if (it + 1 == MAX_ATTEMPTS) begin
                total++;
                if (state !== C_FAIL || failed !== 1'b1 || reached_target !== 1'b0
                    || attempt !== 3'(MAX_ATTEMPTS) || transmit_ir !== 1'b0) begin
                    bad++;
                    $display("FAIL give_up state=%0d fl=%0b rch=%0b att=%0d want %0d/1/0/%0d",
                             state, failed, reached_target, attempt, C_FAIL, MAX_ATTEMPTS);
                end
                return;
            end else begin
                wait_sig(W_OR, 10, n);
                total++;
                if (n !== 0 || orient_from !== loc3 || orient_to !== tgt) begin
                    bad++;
                    $display("FAIL retry_orient wait=%0d from=%0h to=%0h want 0/%0h/%0h",
                             n, orient_from, orient_to, loc3, tgt);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++;
        if ({run_ultrasound, orient_start, orient_from, orient_to, path_start, cmp_start,
             move_command, transmit_ir, orientation, attempt, busy, reached_target,
             failed, state} !== '0) begin
            bad++;
            $display("FAIL reset_outputs state=%0d busy=%0b cmd=%0h want all 0", state, busy, move_command);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_happy();
        mission(0, 12'h203, 12'h000, 1'b1, 1'b0);
    endtask

    task automatic test_retry();
        mission(0, LOC_W'($urandom_range(255, 0)), LOC_W'($urandom_range(255, 0)), 1'b0, 1'b0);
    endtask

    task automatic test_zero_move();
        mission(0, 12'h000, 12'h101, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        mission(2, 12'h000, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        mission(1, 12'h011, 12'h000, 1'b0, 1'b0);
        enable = 1'b1;
        step();
        enable = 1'b0;
        total++;
        if (state !== C_SENSE1 || attempt !== 3'd0 || run_ultrasound !== 1'b1) begin
            bad++;
            $display("FAIL restart state=%0d att=%0d run=%0b want %0d/0/1", state, attempt,
                     run_ultrasound, C_SENSE1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (state !== C_IDLE) begin
            bad++;
            $display("FAIL abort_sense got=%0d want=%0d", state, C_IDLE);
        end
    endtask

    task automatic test_async_reset();
        mission(3, 12'h000, 12'h000, 1'b0, 1'b0);
        mission(4, 12'h000, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_stray_done();
        ultrasound_done = 1'b1;
        orient_done = 1'b1;
        path_done = 1'b1;
        cmp_done = 1'b1;
        cmp_equal = 1'b1;
        step();
        step();
        ultrasound_done = 1'b0;
        orient_done = 1'b0;
        path_done = 1'b0;
        cmp_done = 1'b0;
        cmp_equal = 1'b0;
        total++;
        if (state !== C_IDLE || busy !== 1'b0 || orient_start !== 1'b0 || path_start !== 1'b0
            || cmp_start !== 1'b0 || run_ultrasound !== 1'b0 || reached_target !== 1'b0) begin
            bad++;
            $display("FAIL stray_done state=%0d busy=%0b os=%0b ps=%0b cs=%0b want IDLE and quiet",
                     state, busy, orient_start, path_start, cmp_start);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            mission(0, {4'($urandom), 4'h0, 4'($urandom)}, {4'($urandom), 4'h0, 4'($urandom)},
                    1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_retry();
        test_zero_move();
        test_timeout();
        test_abort();
        test_async_reset();
        test_stray_done();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
